// File: rtl/instruction_fetch.sv
// Instruction fetch stage: keeps the next fetch address, issues single
// outstanding reads to instruction memory, and presents the fetched
// instruction with its PC to decode. A redirect that arrives while a read
// is in flight marks that read stale; its data is dropped and the fetch is
// replayed from the redirected address.
module instruction_fetch #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]      NOP_INST     = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            phase_fetch,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] curr_pc_fd,
    output logic [XLEN-1:0] next_pc_fd,
    output logic            stall_fetch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REFETCH
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state_q, state_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] curr_pc_q, curr_pc_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_aligned;

    // Sequential addition wraps naturally; redirect targets are word aligned.
    assign pc_plus4         = pc_q + PC_STEP;
    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    // Next-state and datapath updates for the fetch controller.
    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        curr_pc_d   = curr_pc_q;
        next_pc_d   = next_pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;

        case (state_q)
            S_IDLE: begin
                if (redirect_en) begin
                    pc_d = redirect_aligned;
                end else if (phase_fetch) begin
                    state_d     = S_WAIT;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = S_REFETCH;
                    end else begin
                        inst_d    = imem_rdata;
                        curr_pc_d = pc_q;
                        next_pc_d = pc_plus4;
                        pc_d      = pc_plus4;
                        state_d   = S_IDLE;
                    end
                    if (redirect_en) begin
                        pc_d = redirect_aligned;
                    end
                end else if (redirect_en) begin
                    pc_d    = redirect_aligned;
                    flush_d = 1'b1;
                end
            end
            S_REFETCH: begin
                state_d    = S_WAIT;
                imem_req_d = 1'b1;
                if (redirect_en) begin
                    pc_d        = redirect_aligned;
                    imem_addr_d = redirect_aligned;
                end else begin
                    imem_addr_d = pc_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flush_q     <= 1'b0;
            pc_q        <= RESET_VECTOR;
            inst_q      <= NOP_INST;
            curr_pc_q   <= RESET_VECTOR;
            next_pc_q   <= RESET_VECTOR;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_VECTOR;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            curr_pc_q   <= curr_pc_d;
            next_pc_q   <= next_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign inst        = inst_q;
    assign curr_pc_fd  = curr_pc_q;
    assign next_pc_fd  = next_pc_q;
    assign stall_fetch = (state_q == S_WAIT) || (state_q == S_REFETCH);

endmodule
